// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection sequencer and its controller/display path.
// tick is a one-cycle strobe (no ready/back-pressure); every output is a registered level.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic       ped_req1;
  logic       ped_req2;
  logic       emerg_req;
  logic       emerg_dir;
  logic [2:0] light1;
  logic [2:0] light2;
  logic [7:0] count;
  logic       walk1;
  logic       walk2;
  logic       ped_pend1;
  logic       ped_pend2;
  logic       emerg_act;
  logic [2:0] phase_dbg;

  modport master (
    output tick, ped_req1, ped_req2, emerg_req, emerg_dir,
    input  light1, light2, count, walk1, walk2, ped_pend1, ped_pend2, emerg_act, phase_dbg
  );

  modport slave (
    input  tick, ped_req1, ped_req2, emerg_req, emerg_dir,
    output light1, light2, count, walk1, walk2, ped_pend1, ped_pend2, emerg_act, phase_dbg
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase sequencer: G1 Y1 AR1 G2 Y2 AR2, pedestrian green truncation.
// Define EMERG_PREEMPT_EN to enable emergency-vehicle preemption.
module traffic_phase_scheduler #(
  parameter int GREEN1_T = 20,
  parameter int GREEN2_T = 15,
  parameter int YEL_T    = 5,
  parameter int ALLRED_T = 2,
  parameter int MIN_GRN  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  traffic_phase_scheduler_if.slave  bus
);

  localparam logic [2:0] S_G1  = 3'd0;
  localparam logic [2:0] S_Y1  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_G2  = 3'd3;
  localparam logic [2:0] S_Y2  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;

  localparam logic [7:0] G1_LEN  = 8'(GREEN1_T);
  localparam logic [7:0] G2_LEN  = 8'(GREEN2_T);
  localparam logic [7:0] YEL_LEN = 8'(YEL_T);
  localparam logic [7:0] AR_LEN  = 8'(ALLRED_T);
  localparam logic [7:0] MIN_LEN = 8'(MIN_GRN);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       ped_pend1_q, ped_pend1_d;
  logic       ped_pend2_q, ped_pend2_d;
  logic [2:0] light1_q, light1_d;
  logic [2:0] light2_q, light2_d;
  logic       walk1_q, walk1_d;
  logic       walk2_q, walk2_d;

  function automatic logic [7:0] phase_len(input logic [2:0] s);
    case (s)
      S_G1:       phase_len = G1_LEN;
      S_G2:       phase_len = G2_LEN;
      S_Y1, S_Y2: phase_len = YEL_LEN;
      default:    phase_len = AR_LEN;
    endcase
  endfunction

  function automatic logic [2:0] phase_next(input logic [2:0] s);
    case (s)
      S_G1:    phase_next = S_Y1;
      S_Y1:    phase_next = S_AR1;
      S_AR1:   phase_next = S_G2;
      S_G2:    phase_next = S_Y2;
      S_Y2:    phase_next = S_AR2;
      default: phase_next = S_G1;
    endcase
  endfunction

`ifdef EMERG_PREEMPT_EN
  logic       emerg_act_q, emerg_act_d;
  logic       emerg_dir_q, emerg_dir_d;
  logic       dir_eff;
  logic [2:0] req_g, opp_g, held_g;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.tick) begin
      if (count_q == 8'd1) begin
        state_d = phase_next(state_q);
        count_d = phase_len(state_d);
      end else begin
        count_d = count_q - 8'd1;
      end
    end
    // A request arriving this cycle truncates immediately, not one cycle later.
    if (state_q == S_G1 && (ped_pend1_q || bus.ped_req1) && count_q > MIN_LEN)
      count_d = MIN_LEN;
    if (state_q == S_G2 && (ped_pend2_q || bus.ped_req2) && count_q > MIN_LEN)
      count_d = MIN_LEN;

`ifdef EMERG_PREEMPT_EN
    // Direction is captured on the first request cycle and held while active.
    dir_eff     = emerg_act_q ? emerg_dir_q : bus.emerg_dir;
    req_g       = dir_eff ? S_G2 : S_G1;
    opp_g       = dir_eff ? S_G1 : S_G2;
    held_g      = emerg_dir_q ? S_G2 : S_G1;
    emerg_act_d = bus.emerg_req;
    emerg_dir_d = (bus.emerg_req && !emerg_act_q) ? bus.emerg_dir : emerg_dir_q;
    if (bus.emerg_req) begin
      if (state_q == opp_g) begin
        state_d = dir_eff ? S_Y1 : S_Y2;
        count_d = YEL_LEN;
      end else if (state_q == req_g) begin
        state_d = state_q;
        count_d = count_q;
      end
    end else if (emerg_act_q && state_q == held_g) begin
      count_d = phase_len(state_q);
    end
`endif

    ped_pend1_d = (ped_pend1_q || bus.ped_req1) && !(state_d == S_G2 && state_q != S_G2);
    ped_pend2_d = (ped_pend2_q || bus.ped_req2) && !(state_d == S_G1 && state_q != S_G1);

    light1_d = LAMP_R;
    light2_d = LAMP_R;
    case (state_d)
      S_G1:    light1_d = LAMP_G;
      S_Y1:    light1_d = LAMP_Y;
      S_G2:    light2_d = LAMP_G;
      S_Y2:    light2_d = LAMP_Y;
      default: ;
    endcase
    walk1_d = (state_d == S_G2);
    walk2_d = (state_d == S_G1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_AR2;
      count_q     <= AR_LEN;
      ped_pend1_q <= 1'b0;
      ped_pend2_q <= 1'b0;
      light1_q    <= LAMP_R;
      light2_q    <= LAMP_R;
      walk1_q     <= 1'b0;
      walk2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ped_pend1_q <= ped_pend1_d;
      ped_pend2_q <= ped_pend2_d;
      light1_q    <= light1_d;
      light2_q    <= light2_d;
      walk1_q     <= walk1_d;
      walk2_q     <= walk2_d;
    end
  end

`ifdef EMERG_PREEMPT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      emerg_act_q <= 1'b0;
      emerg_dir_q <= 1'b0;
    end else begin
      emerg_act_q <= emerg_act_d;
      emerg_dir_q <= emerg_dir_d;
    end
  end
  assign bus.emerg_act = emerg_act_q;
`else
  logic unused_emerg;
  assign unused_emerg  = bus.emerg_req ^ bus.emerg_dir;
  assign bus.emerg_act = 1'b0;
`endif

  assign bus.light1    = light1_q;
  assign bus.light2    = light2_q;
  assign bus.count     = count_q;
  assign bus.walk1     = walk1_q;
  assign bus.walk2     = walk2_q;
  assign bus.ped_pend1 = ped_pend1_q;
  assign bus.ped_pend2 = ped_pend2_q;
  assign bus.phase_dbg = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios then random traffic, checked each
// cycle against a phase-table reference model (preemption modelled when EMERG_PREEMPT_EN).
module tb_traffic_phase_scheduler;
  localparam int GREEN1_T = 20;
  localparam int GREEN2_T = 15;
  localparam int YEL_T    = 5;
  localparam int ALLRED_T = 2;
  localparam int MIN_GRN  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler #(
    .GREEN1_T(GREEN1_T), .GREEN2_T(GREEN2_T), .YEL_T(YEL_T),
    .ALLRED_T(ALLRED_T), .MIN_GRN(MIN_GRN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- reference model ----------------
  // Phase index 0..5 = G1 Y1 AR1 G2 Y2 AR2; sequence is index+1 modulo 6.
  int         dur_tab[6]   = '{GREEN1_T, YEL_T, ALLRED_T, GREEN2_T, YEL_T, ALLRED_T};
  logic [2:0] lamp1_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] lamp2_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int   m_ph, m_cnt;
  bit   m_p1, m_p2, m_ea, m_dir;
  logic [7:0] exp_q[$];

  int total = 0;
  int bad   = 0;
  bit cur_er = 1'b0;
  bit cur_ed = 1'b0;

  task automatic model_step(input bit t, input bit r1, input bit r2,
                            input bit er, input bit ed, input bit rn);
    int n_ph, n_cnt;
    bit n_ea, n_dir;
    if (!rn) begin
      m_ph = 5; m_cnt = ALLRED_T; m_p1 = 0; m_p2 = 0; m_ea = 0; m_dir = 0;
    end else begin
      n_ph = m_ph; n_cnt = m_cnt; n_ea = 0; n_dir = m_dir;
      if (t) begin
        if (m_cnt == 1) begin
          n_ph  = (m_ph + 1) % 6;
          n_cnt = dur_tab[n_ph];
        end else begin
          n_cnt = m_cnt - 1;
        end
      end
      if (m_ph == 0 && (m_p1 || r1) && m_cnt > MIN_GRN) n_cnt = MIN_GRN;
      if (m_ph == 3 && (m_p2 || r2) && m_cnt > MIN_GRN) n_cnt = MIN_GRN;
`ifdef EMERG_PREEMPT_EN
      begin
        bit d;
        d = m_ea ? m_dir : ed;
        if (er) begin
          if (m_ph == (d ? 0 : 3)) begin
            n_ph  = d ? 1 : 4;
            n_cnt = YEL_T;
          end else if (m_ph == (d ? 3 : 0)) begin
            n_ph  = m_ph;
            n_cnt = m_cnt;
          end
        end else if (m_ea && m_ph == (m_dir ? 3 : 0)) begin
          n_cnt = dur_tab[m_ph];
        end
        n_dir = (er && !m_ea) ? ed : m_dir;
        n_ea  = er;
      end
`endif
      m_p1  = (m_p1 || r1) && !(n_ph == 3 && m_ph != 3);
      m_p2  = (m_p2 || r2) && !(n_ph == 0 && m_ph != 0);
      m_ph  = n_ph;
      m_cnt = n_cnt;
      m_ea  = n_ea;
      m_dir = n_dir;
    end
    exp_q.push_back(8'(m_cnt));
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ec;
    ec = exp_q.pop_front();
    chk({tag, ".count"},     32'(bus.count),     32'(ec));
    chk({tag, ".light1"},    32'(bus.light1),    32'(lamp1_tab[m_ph]));
    chk({tag, ".light2"},    32'(bus.light2),    32'(lamp2_tab[m_ph]));
    chk({tag, ".walk1"},     32'(bus.walk1),     32'(m_ph == 3));
    chk({tag, ".walk2"},     32'(bus.walk2),     32'(m_ph == 0));
    chk({tag, ".ped_pend1"}, 32'(bus.ped_pend1), 32'(m_p1));
    chk({tag, ".ped_pend2"}, 32'(bus.ped_pend2), 32'(m_p2));
    chk({tag, ".emerg_act"}, 32'(bus.emerg_act), 32'(m_ea));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit t, input bit r1, input bit r2,
                     input bit er, input bit ed, input bit rn, input string tag);
    bus.tick      = t;
    bus.ped_req1  = r1;
    bus.ped_req2  = r2;
    bus.emerg_req = er;
    bus.emerg_dir = ed;
    rst_n         = rn;
    model_step(t, r1, r2, er, ed, rn);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Tick every cycle until the model reaches the target phase/count (bounded).
  task automatic tick_to(input int ph, input int cnt, input string tag);
    for (int i = 0; i < 400; i++) begin
      if (m_ph == ph && m_cnt == cnt) break;
      cyc(1'b1, 1'b0, 1'b0, cur_er, cur_ed, 1'b1, tag);
    end
    chk({tag, ".reach_count"}, 32'(bus.count), 32'(cnt));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.tick = 0; bus.ped_req1 = 0; bus.ped_req2 = 0;
    bus.emerg_req = 0; bus.emerg_dir = 0; rst_n = 0;
    m_ph = 5; m_cnt = ALLRED_T; m_p1 = 0; m_p2 = 0; m_ea = 0; m_dir = 0;

    // T1: reset values, then a full cycle with a tick every 4 clocks
    cyc(0, 0, 0, 0, 0, 0, "rst");
    cyc(0, 0, 0, 0, 0, 0, "rst");
    chk("rst.count_const",  32'(bus.count),  32'd2);
    chk("rst.light1_const", 32'(bus.light1), 32'b100);
    chk("rst.light2_const", 32'(bus.light2), 32'b100);
    for (int i = 0; i < 4 * 55; i++)
      cyc((i % 4) == 3, 0, 0, 0, 0, 1, "t1");

    // T2: pedestrian pulse at G1 count 18 truncates to MIN_GRN next clock
    tick_to(0, 18, "t2.pos");
    cyc(0, 1, 0, 0, 0, 1, "t2.req");
    chk("t2.trunc_count", 32'(bus.count),     32'd5);
    chk("t2.pend_set",    32'(bus.ped_pend1), 32'd1);
    tick_to(3, 15, "t2.g2");
    chk("t2.walk1",       32'(bus.walk1),     32'd1);
    chk("t2.pend_clr",    32'(bus.ped_pend1), 32'd0);

    // T3: request late in G2 never lengthens the phase
    tick_to(3, 3, "t3.pos");
    cyc(0, 0, 1, 0, 0, 1, "t3.req");
    chk("t3.no_trunc", 32'(bus.count), 32'd3);
    cyc(1, 0, 0, 0, 0, 1, "t3.dec");
    chk("t3.cnt2", 32'(bus.count), 32'd2);
    cyc(1, 0, 0, 0, 0, 1, "t3.dec");
    chk("t3.cnt1", 32'(bus.count), 32'd1);

    // T4: truncation together with a tick loads MIN_GRN, not MIN_GRN-1
    tick_to(0, 12, "t4.pos");
    cyc(1, 1, 0, 0, 0, 1, "t4.req");
    chk("t4.trunc_tick", 32'(bus.count), 32'd5);

    // T6: reset pulse in Y2 drops a pending request
    tick_to(3, 14, "t6.g2");
    cyc(0, 1, 0, 0, 0, 1, "t6.req");
    tick_to(4, 3, "t6.y2");
    chk("t6.pend_before", 32'(bus.ped_pend1), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, "t6.rst");
    chk("t6.count",  32'(bus.count),     32'd2);
    chk("t6.pend",   32'(bus.ped_pend1), 32'd0);
    chk("t6.light1", 32'(bus.light1),    32'b100);

`ifdef EMERG_PREEMPT_EN
    // T5: preempt toward road 2 from G1 count 14
    tick_to(0, 14, "t5.pos");
    cur_er = 1; cur_ed = 1;
    cyc(0, 0, 0, 1, 1, 1, "t5.jump");
    chk("t5.yel_count", 32'(bus.count),  32'd5);
    chk("t5.yel_lamp",  32'(bus.light1), 32'b010);
    tick_to(3, 15, "t5.g2");
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 1, 1, 1, "t5.hold");
      chk("t5.frozen", 32'(bus.count), 32'd15);
    end
    cur_er = 0;
    cyc(0, 0, 0, 0, 1, 1, "t5.drop");
    chk("t5.reload", 32'(bus.count), 32'd15);
    cyc(1, 0, 0, 0, 1, 1, "t5.after");
`else
    // Preemption inputs must have no effect in this build
    tick_to(0, 14, "t5.pos");
    cyc(0, 0, 0, 1, 1, 1, "t5.ignored");
    chk("t5.no_jump", 32'(bus.count),  32'd14);
    chk("t5.no_act",  32'(bus.emerg_act), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bit t, r1, r2, rn;
      t  = ($urandom_range(0, 2) == 0);
      r1 = ($urandom_range(0, 15) == 0);
      r2 = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) cur_er = ~cur_er;
      if ($urandom_range(0, 9) == 0)  cur_ed = 1'($urandom_range(0, 1));
      cyc(t, r1, r2, cur_er, cur_ed, rn, "rand");
    end

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
